// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM states, bus layouts and res_from_mem decoding.
package mem_stage_pkg;

  localparam int EM_BUS_WID     = 195;
  localparam int MW_BUS_WID     = 191;
  localparam int MD_FOR_BUS_WID = 117;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_WAIT   = 2'd1,
    M_DONE   = 2'd2,
    M_CANCEL = 2'd3
  } m_state_e;

  localparam int RFM_BYTE = 0;
  localparam int RFM_HALF = 1;
  localparam int RFM_ZEXT = 2;
  localparam int RFM_WORD = 3;

  // A store carries the extension bit alone: no size bit, so it never selects load data.
  localparam logic [3:0] RFM_STORE = 4'b0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rf_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  res_from_mem;
    logic [31:0] vaddr;
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } em_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rf_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] vaddr;
  } mw_bus_t;

  typedef struct packed {
    logic        load_busy;
    logic [4:0]  dest_masked;
    logic [31:0] rf_wdata;
    logic        csr_we_v;
    logic [13:0] csr_addr;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } md_bus_t;

  function automatic logic is_load(input logic [3:0] rfm);
    return rfm[RFM_WORD] | rfm[RFM_HALF] | rfm[RFM_BYTE];
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side signals of the memory stage; master drives Excute/WB/SRAM inputs, slave is the stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic        W_allowin;
  logic        M_allowin;
  logic        EM_valid;
  em_bus_t     EM_BUS;
  logic        MW_valid;
  mw_bus_t     MW_BUS;
  md_bus_t     MD_for_BUS;
  logic        ex_en;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output W_allowin, EM_valid, EM_BUS, ex_en, data_sram_data_ok, data_sram_rdata,
    input  M_allowin, MW_valid, MW_BUS, MD_for_BUS
  );

  modport slave (
    input  W_allowin, EM_valid, EM_BUS, ex_en, data_sram_data_ok, data_sram_rdata,
    output M_allowin, MW_valid, MW_BUS, MD_for_BUS
  );
endinterface

// File: rtl/mem_load_ext.sv
// Load data alignment and sign/zero extension for byte, half and word loads.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  vaddr_i,
  input  logic [3:0]  res_from_mem_i,
  output logic [31:0] rf_wdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    case (vaddr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = vaddr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sext     = ~res_from_mem_i[RFM_ZEXT];

    if (res_from_mem_i[RFM_WORD])      rf_wdata_o = rdata_i;
    else if (res_from_mem_i[RFM_HALF]) rf_wdata_o = {{16{sext & half_sel[15]}}, half_sel};
    else if (res_from_mem_i[RFM_BYTE]) rf_wdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
    else                               rf_wdata_o = rdata_i;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: waits for the data-SRAM response, aligns load data, drives MW and M->D forward buses.
//   state    | meaning
//   M_IDLE   | no access outstanding
//   M_WAIT   | captured instruction has an access outstanding
//   M_DONE   | response held in rdata_buf until Writeback accepts
//   M_CANCEL | flushed access still outstanding, its response will be dropped
module mem_stage
  import mem_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave m
);

  m_state_e    state_q, state_d;
  logic        m_valid_q, m_valid_d;
  em_bus_t     em_q, em_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        mem_op, ready_go, allowin, capture, capture_mem, dok;
  logic [31:0] ld_src, ld_data, rf_wdata_m;
  mw_bus_t     mw;
  md_bus_t     md;

  assign dok         = m.data_sram_data_ok;
  assign mem_op      = m_valid_q && !em_q.ex && (|em_q.res_from_mem);
  assign ready_go    = !mem_op || (state_q == M_WAIT && dok) || (state_q == M_DONE);
  assign allowin     = (!m_valid_q || (ready_go && m.W_allowin)) && (state_q != M_CANCEL);
  assign capture     = m.EM_valid && allowin && !m.ex_en;
  assign capture_mem = capture && !m.EM_BUS.ex && (|m.EM_BUS.res_from_mem);

  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    em_d        = em_q;
    rdata_buf_d = rdata_buf_q;
    if (state_q == M_WAIT && dok) rdata_buf_d = m.data_sram_rdata;
    if (m.ex_en) begin
      m_valid_d = 1'b0;
      case (state_q)
        M_WAIT, M_CANCEL: state_d = dok ? M_IDLE : M_CANCEL;
        default:          state_d = M_IDLE;
      endcase
    end else begin
      if (allowin) m_valid_d = m.EM_valid;
      if (capture) em_d = m.EM_BUS;
      case (state_q)
        M_IDLE:   if (capture_mem) state_d = M_WAIT;
        M_WAIT:   if (dok) state_d = !m.W_allowin ? M_DONE : (capture_mem ? M_WAIT : M_IDLE);
        M_DONE:   if (m.W_allowin) state_d = capture_mem ? M_WAIT : M_IDLE;
        default:  if (dok) state_d = M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= M_IDLE;
      m_valid_q   <= 1'b0;
      em_q        <= '0;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      em_q        <= em_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign ld_src = (state_q == M_DONE) ? rdata_buf_q : m.data_sram_rdata;

  mem_load_ext u_load_ext (
    .rdata_i        (ld_src),
    .vaddr_i        (em_q.vaddr[1:0]),
    .res_from_mem_i (em_q.res_from_mem),
    .rf_wdata_o     (ld_data)
  );

  // Excepted loads never fetched data, so keep the bus value rather than SRAM noise.
  assign rf_wdata_m = (is_load(em_q.res_from_mem) && !em_q.ex) ? ld_data : em_q.rf_wdata;

  always_comb begin
    mw.pc        = em_q.pc;
    mw.rf_wdata  = rf_wdata_m;
    mw.gr_we     = em_q.gr_we && !em_q.ex;
    mw.dest      = em_q.dest;
    mw.ex        = em_q.ex;
    mw.ecode     = em_q.ecode;
    mw.esubcode  = em_q.esubcode;
    mw.csr_addr  = em_q.csr_addr;
    mw.csr_we    = em_q.csr_we;
    mw.csr_wmask = em_q.csr_wmask;
    mw.csr_wdata = em_q.csr_wdata;
    mw.vaddr     = em_q.vaddr;

    md.load_busy   = m_valid_q && is_load(em_q.res_from_mem) && !ready_go;
    md.dest_masked = em_q.dest & {5{m_valid_q && em_q.gr_we && !em_q.ex}};
    md.rf_wdata    = rf_wdata_m;
    md.csr_we_v    = em_q.csr_we && m_valid_q;
    md.csr_addr    = em_q.csr_addr;
    md.csr_wmask   = em_q.csr_wmask;
    md.csr_wdata   = em_q.csr_wdata;
  end

  assign m.M_allowin  = allowin;
  assign m.MW_valid   = m_valid_q && ready_go;
  assign m.MW_BUS     = mw;
  assign m.MD_for_BUS = md;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and random bench for mem_stage against a transaction-level model of the stage and SRAM.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if m_if ();
  mem_stage dut (.clk(clk), .rst(rst), .m(m_if));

  int n_checks = 0;
  int n_err    = 0;
  logic chk_on;

  // model: instruction held in M, plus the single outstanding SRAM response
  logic        m_vld, m_mem, m_load, m_got;
  em_bus_t     m_ins;
  logic [31:0] m_data;
  logic        pend;
  int          cnt;
  logic [31:0] pdata;
  int          nxt_delay;
  logic [31:0] nxt_data;

  logic    obs_mwv, obs_allow;
  mw_bus_t obs_mw;
  md_bus_t obs_md;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] ref_ld(input logic [31:0] d, input logic [1:0] a, input logic [3:0] f);
    logic [31:0] v;
    int bits;
    if (f[3]) return d;
    if (f[1]) begin
      v = (d >> (int'(a[1]) * 16)) & 32'hFFFF;
      bits = 16;
    end else begin
      v = (d >> (int'(a) * 8)) & 32'hFF;
      bits = 8;
    end
    if (!f[2] && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic mw_bus_t exp_mw();
    mw_bus_t e;
    e.pc        = m_ins.pc;
    e.rf_wdata  = (m_load && !m_ins.ex) ? ref_ld(m_data, m_ins.vaddr[1:0], m_ins.res_from_mem)
                                        : m_ins.rf_wdata;
    e.gr_we     = m_ins.gr_we && !m_ins.ex;
    e.dest      = m_ins.dest;
    e.ex        = m_ins.ex;
    e.ecode     = m_ins.ecode;
    e.esubcode  = m_ins.esubcode;
    e.csr_addr  = m_ins.csr_addr;
    e.csr_we    = m_ins.csr_we;
    e.csr_wmask = m_ins.csr_wmask;
    e.csr_wdata = m_ins.csr_wdata;
    e.vaddr     = m_ins.vaddr;
    return e;
  endfunction

  function automatic em_bus_t mk(input logic [4:0] dest, input logic [3:0] rfm, input logic [31:0] vaddr,
                                 input logic [31:0] wdata, input logic gr_we);
    em_bus_t e = '0;
    e.pc = 32'h1c00_0000 + {27'd0, dest};
    e.dest = dest;
    e.res_from_mem = rfm;
    e.vaddr = vaddr;
    e.rf_wdata = wdata;
    e.gr_we = gr_we;
    return e;
  endfunction

  function automatic logic [3:0] rand_ldop();
    logic z;
    int s;
    z = 1'($urandom);
    s = int'($urandom % 3);
    if (s == 0) return 4'b1000;
    if (s == 1) return {1'b0, z, 2'b10};
    return {1'b0, z, 2'b01};
  endfunction

  function automatic em_bus_t rand_ins();
    em_bus_t e;
    int k;
    e.pc = $urandom; e.rf_wdata = $urandom; e.gr_we = 1'($urandom);
    e.dest = 5'($urandom); e.vaddr = $urandom; e.ex = 1'b0;
    e.ecode = 8'($urandom); e.esubcode = 1'($urandom); e.csr_addr = 14'($urandom);
    e.csr_we = 1'($urandom); e.csr_wmask = $urandom; e.csr_wdata = $urandom;
    e.res_from_mem = 4'b0000;
    k = int'($urandom % 8);
    if (k < 3) begin
      e.res_from_mem = rand_ldop(); e.gr_we = 1'b1;
    end else if (k == 3) begin
      e.res_from_mem = RFM_STORE; e.gr_we = 1'b0;
    end else if (k == 4) begin
      e.ex = 1'b1; e.res_from_mem = rand_ldop();
    end
    return e;
  endfunction

  task automatic cycle();
    logic dok, ready, e_mwv, e_allow, orphan, fire;
    dok = pend && (cnt == 0);
    m_if.data_sram_data_ok = dok;
    m_if.data_sram_rdata   = dok ? pdata : $urandom;
    @(negedge clk);
    obs_mwv = m_if.MW_valid; obs_allow = m_if.M_allowin;
    obs_mw = m_if.MW_BUS; obs_md = m_if.MD_for_BUS;
    ready   = !m_mem || m_got || dok;
    e_mwv   = m_vld && ready;
    orphan  = pend && !m_vld;
    e_allow = (!m_vld || (ready && m_if.W_allowin)) && !orphan;
    if (chk_on) begin
      chk("mw_valid", obs_mwv, e_mwv);
      chk("m_allowin", obs_allow, e_allow);
      chk("load_busy", obs_md.load_busy, m_vld && m_load && !ready);
      chk("dest_masked", obs_md.dest_masked, (m_vld && m_ins.gr_we && !m_ins.ex) ? m_ins.dest : 5'd0);
      chk("csr_we_v", obs_md.csr_we_v, m_vld && m_ins.csr_we);
      if (e_mwv) begin
        chk("mw_bus", obs_mw, exp_mw());
        chk("md_rf_wdata", obs_md.rf_wdata, exp_mw().rf_wdata);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0; pend = 1'b0; m_got = 1'b0; m_mem = 1'b0; m_load = 1'b0;
    end else begin
      if (dok) pend = 1'b0;
      else if (pend) cnt--;
      if (m_if.ex_en) m_vld = 1'b0;
      else begin
        fire = e_mwv && m_if.W_allowin;
        if (fire) m_vld = 1'b0;
        else if (dok && m_vld) m_got = 1'b1;
        if (m_if.EM_valid && e_allow) begin
          m_vld  = 1'b1;
          m_ins  = m_if.EM_BUS;
          m_load = m_ins.res_from_mem[3] | m_ins.res_from_mem[1] | m_ins.res_from_mem[0];
          m_mem  = !m_ins.ex && (m_ins.res_from_mem != 4'b0000);
          m_got  = 1'b0;
          m_data = nxt_data;
          if (m_mem) begin
            pend = 1'b1; cnt = nxt_delay - 1; pdata = nxt_data;
          end
        end
      end
    end
    #1;
  endtask

  task automatic issue(input em_bus_t e, input int delay, input logic [31:0] data);
    m_if.EM_valid = 1'b1; m_if.EM_BUS = e;
    nxt_delay = delay; nxt_data = data;
    cycle();
    m_if.EM_valid = 1'b0;
  endtask

  initial begin
    m_vld = 0; m_mem = 0; m_load = 0; m_got = 0; m_ins = '0; m_data = '0;
    pend = 0; cnt = 0; pdata = '0; nxt_delay = 1; nxt_data = '0;
    rst = 1'b1; chk_on = 1'b0;
    m_if.W_allowin = 1'b1; m_if.EM_valid = 1'b0; m_if.EM_BUS = '0; m_if.ex_en = 1'b0;
    m_if.data_sram_data_ok = 1'b0; m_if.data_sram_rdata = '0;
    repeat (2) cycle();
    chk_on = 1'b1;
    cycle();
    chk("reset_md", obs_md, '0);
    chk("reset_mwv", obs_mwv, 1'b0);
    chk("reset_allow", obs_allow, 1'b1);
    rst = 1'b0;
    cycle();

    // sign-extended byte at offset 3
    issue(mk(5'd1, 4'b0001, 32'h1003, 32'h0, 1'b1), 1, 32'h80FF1234);
    cycle();
    chk("ldb_mwv", obs_mwv, 1'b1);
    chk("ldb_data", obs_mw.rf_wdata, 32'hFFFFFF80);

    // zero-extended upper half
    issue(mk(5'd2, 4'b0110, 32'h1002, 32'h0, 1'b1), 1, 32'h80FF1234);
    cycle();
    chk("ldhu_data", obs_mw.rf_wdata, 32'h000080FF);

    // back-pressure: response held while Writeback stalls
    m_if.W_allowin = 1'b0;
    issue(mk(5'd3, 4'b1000, 32'h2000, 32'h0, 1'b1), 1, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_busy", obs_md.load_busy, 1'b0);
      chk("bp_allow", obs_allow, 1'b0);
      chk("bp_data", obs_mw.rf_wdata, 32'hDEADBEEF);
    end
    m_if.W_allowin = 1'b1;
    cycle();
    chk("bp_release_mwv", obs_mwv, 1'b1);
    chk("bp_release_data", obs_mw.rf_wdata, 32'hDEADBEEF);

    // flush in WAIT, stale response arrives two cycles later
    issue(mk(5'd4, 4'b1000, 32'h3000, 32'h0, 1'b1), 3, 32'h11111111);
    m_if.ex_en = 1'b1;
    cycle();
    m_if.ex_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("flush_allow", obs_allow, 1'b0);
      chk("flush_mwv", obs_mwv, 1'b0);
    end
    issue(mk(5'd5, 4'b1000, 32'h3004, 32'h0, 1'b1), 1, 32'h22222222);
    chk("flush_reopen", obs_allow, 1'b1);
    cycle();
    chk("flush_next_data", obs_mw.rf_wdata, 32'h22222222);

    // exception passthrough
    begin
      em_bus_t e;
      e = mk(5'd7, 4'b0001, 32'h4001, 32'h0, 1'b1);
      e.ex = 1'b1; e.ecode = 8'h09;
      issue(e, 1, 32'h0);
      cycle();
      chk("ex_mwv", obs_mwv, 1'b1);
      chk("ex_gr_we", obs_mw.gr_we, 1'b0);
      chk("ex_flag", obs_mw.ex, 1'b1);
      chk("ex_ecode", obs_mw.ecode, 8'h09);
      chk("ex_dest", obs_md.dest_masked, 5'd0);
      chk("ex_allow", obs_allow, 1'b1);
    end

    // forwarding: ALU result then a load that stalls decode
    issue(mk(5'd5, 4'b0000, 32'h0, 32'h12345678, 1'b1), 1, 32'h0);
    issue(mk(5'd6, 4'b1000, 32'h5000, 32'h0, 1'b1), 2, 32'hCAFEF00D);
    chk("fwd_dest", obs_md.dest_masked, 5'd5);
    chk("fwd_data", obs_md.rf_wdata, 32'h12345678);
    cycle();
    chk("fwd_busy", obs_md.load_busy, 1'b1);
    chk("fwd_ld_dest", obs_md.dest_masked, 5'd6);
    cycle();
    chk("fwd_busy_clear", obs_md.load_busy, 1'b0);
    chk("fwd_ld_data", obs_md.rf_wdata, 32'hCAFEF00D);

    // reset while a load is outstanding
    issue(mk(5'd8, 4'b1000, 32'h6000, 32'h0, 1'b1), 3, 32'h33333333);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_wait_md", obs_md, '0);
      chk("rst_wait_allow", obs_allow, 1'b1);
    end

    for (int i = 0; i < 3000; i++) begin
      m_if.EM_valid  = ($urandom % 3) != 0;
      m_if.EM_BUS    = rand_ins();
      m_if.W_allowin = ($urandom % 4) != 0;
      m_if.ex_en     = ($urandom % 25) == 0;
      nxt_delay      = 1 + int'($urandom % 3);
      nxt_data       = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
